// File: rtl/cla_nibble_sequencer_if.sv
// Bundle between the nibble sequencer and its environment: operand request,
// result return, and the nibble-wide link to the shared 4-bit CLA stage.
interface cla_nibble_sequencer_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;

   logic [3:0]    cla_a;
   logic [3:0]    cla_b;
   logic          cla_cin;
   logic [3:0]    cla_s;
   logic          cla_cout;

   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          overflow;

   // environment side: supplies operands, the CLA stage and the result consumer
   modport master (
      output in_valid, a, b, cin, sub, cla_s, cla_cout, out_ready,
      input  in_ready, cla_a, cla_b, cla_cin, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, cla_s, cla_cout, out_ready,
      output in_ready, cla_a, cla_b, cla_cin, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Word adder/subtractor that walks one external 4-bit CLA stage across the
// operand, least significant nibble first, one nibble per clock.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | feeding nibble k to the CLA stage, capturing sum/carry each edge
// DONE  | result presented with out_valid, held until out_ready
module cla_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   cla_nibble_sequencer_if.slave  bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic [W-1:0]   sum_reg;
   logic           carry_reg;
   logic           cout_reg;
   logic           ovf_reg;
   logic [KW-1:0]  k;

   logic           accept;
   logic           last_nib;
   logic [3:0]     nib_a;
   logic [3:0]     nib_b;

   assign accept   = bus.in_valid & bus.in_ready;
   assign last_nib = (k == K_LAST);

   // nibble select by compare rather than a computed part-select keeps the
   // index width independent of NIBBLES
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (k == KW'(i)) begin
            nib_a = a_reg[4*i +: 4];
            nib_b = b_reg[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)        state_nxt = S_RUN;
         S_RUN:   if (last_nib)      state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
         default:                    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.cla_a     = 4'h0;
      bus.cla_b     = 4'h0;
      bus.cla_cin   = 1'b0;
      case (state)
         S_IDLE: bus.in_ready = 1'b1;
         S_RUN: begin
            bus.cla_a   = nib_a;
            bus.cla_b   = nib_b;
            bus.cla_cin = carry_reg;
         end
         S_DONE: bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         k         <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.sub ? ~bus.b : bus.b;
                  carry_reg <= bus.sub | bus.cin;
                  sum_reg   <= '0;
                  k         <= '0;
               end
            end
            S_RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (k == KW'(i)) sum_reg[4*i +: 4] <= bus.cla_s;
               end
               carry_reg <= bus.cla_cout;
               if (last_nib) begin
                  k        <= '0;
                  cout_reg <= bus.cla_cout;
                  // carry into the MSB is recovered from the sum bit
                  ovf_reg  <= bus.cla_cout ^ (nib_a[3] ^ nib_b[3] ^ bus.cla_s[3]);
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sum      = sum_reg;
   assign bus.cout     = cout_reg;
   assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: gate-level 4-bit CLA stage plus a word-level
// arithmetic reference model, directed cases followed by random operations.
module tb_cla_nibble_sequencer;
   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cla_nibble_sequencer_if #(.NIBBLES(NIB)) bus ();

   cla_nibble_sequencer #(.NIBBLES(NIB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // combinational 4-bit carry-lookahead stage
   logic [3:0] g, p;
   logic [4:0] c;
   assign g    = bus.cla_a & bus.cla_b;
   assign p    = bus.cla_a ^ bus.cla_b;
   assign c[0] = bus.cla_cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);
   assign bus.cla_s    = p ^ c[3:0];
   assign bus.cla_cout = c[4];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tcin,
                         input logic tsub, input int hold, input bit stuff);
      logic [W-1:0] bb;
      logic         c0;
      logic [W:0]   full;
      logic [W-1:0] es;
      logic         ec, eo;
      logic [31:0]  msk, part;
      int           n;

      bb   = tsub ? ~tb_in : tb_in;
      c0   = tsub ? 1'b1 : tcin;
      full = {1'b0, ta} + {1'b0, bb} + (W+1)'(c0);
      es   = full[W-1:0];
      ec   = full[W];
      eo   = (ta[W-1] == bb[W-1]) && (es[W-1] != ta[W-1]);

      bus.a = ta; bus.b = tb_in; bus.cin = tcin; bus.sub = tsub; bus.in_valid = 1'b1;
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom);
      bus.cin = 1'($urandom); bus.sub = 1'($urandom);

      n = 0;
      while (!bus.out_valid && n < 40) begin
         if (n < NIB) begin
            msk  = (32'd1 << (4*n)) - 32'd1;
            part = ({16'b0, ta} & msk) + ({16'b0, bb} & msk) + 32'(c0);
            chk("cla_a_nib",  32'(bus.cla_a),   32'(ta[4*n +: 4]));
            chk("cla_b_nib",  32'(bus.cla_b),   32'(bb[4*n +: 4]));
            chk("cla_cin_nib", 32'(bus.cla_cin), 32'(part[4*n]));
            chk("in_ready_run", 32'(bus.in_ready), 32'd0);
         end
         bus.out_ready = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      bus.out_ready = 1'b0;
      chk("latency", 32'(n), 32'(NIB));
      if (!bus.out_valid) return;
      chk("sum",      32'(bus.sum),      32'(es));
      chk("cout",     32'(bus.cout),     32'(ec));
      chk("overflow", 32'(bus.overflow), 32'(eo));

      for (int h = 0; h < hold; h++) begin
         if (stuff) begin
            bus.in_valid = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0;
         end
         @(posedge clk); #1;
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_ready", 32'(bus.in_ready),  32'd0);
         chk("hold_sum",   32'(bus.sum),       32'(es));
         chk("hold_cout",  32'(bus.cout),      32'(ec));
         chk("hold_ovf",   32'(bus.overflow),  32'(eo));
      end

      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
      chk("in_ready_back",  32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      bit seen;
      logic [W-1:0] ra, rb;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sum",       32'(bus.sum),       32'd0);
      chk("rst_cout",      32'(bus.cout),      32'd0);
      chk("rst_ovf",       32'(bus.overflow),  32'd0);
      chk("rst_cla_cin",   32'(bus.cla_cin),   32'd0);
      @(posedge clk); #1;

      run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

      // backpressure with a competing request that must wait for IDLE
      run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 3, 1'b1);
      run_op(16'hAAAA, 16'h1111, 1'b0, 1'b0, 0, 1'b0);

      // reset in the middle of RUN
      bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_sum",       32'(bus.sum),       32'd0);
      chk("midrst_cla_a",     32'(bus.cla_a),     32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
